// File: rtl/instruction_fetch.sv
`default_nettype none
// instruction_fetch: owns the PC, fetches words over req/ack and holds the instruction for decode.
// Optional feature macro: MISALIGN_CHECK_EN (adds fetch_exc, halts on misaligned redirect targets).
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  redirect_en,
  input  logic [DATA_WIDTH-1:0] redirect_pc
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                  fetch_exc
`endif
);

  localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(4);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_HOLD  = 3'd1,
    S_DROP  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic [DATA_WIDTH-1:0] pend_pc, pend_next;
  logic [DATA_WIDTH-1:0] instr_next;
  logic                  exc, exc_next;
  logic [DATA_WIDTH-1:0] target;
  logic                  misaligned;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign target     = redirect_pc;
  assign fetch_exc  = exc;
`else
  logic unused_target_lsbs;
  assign misaligned         = 1'b0;
  assign target             = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^redirect_pc[1:0];
`endif

  assign imem_req    = (state == S_FETCH || state == S_DROP || state == S_DRAIN) && !reset;
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign pc_out      = pc;
  assign pc_plus4    = pc + WORD_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      instr   <= '0;
      exc     <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_next;
      instr   <= instr_next;
      exc     <= exc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend_pc;
    instr_next = instr;
    exc_next   = exc;
    case (state)
      S_FETCH: begin
        if (redirect_en) begin
          if (misaligned) begin
            exc_next   = 1'b1;
            state_next = imem_ack ? S_HALT : S_DRAIN;
          end else if (imem_ack) begin
            pc_next = target;
          end else begin
            // imem_addr must stay on the in-flight address, so park the target
            pend_next  = target;
            state_next = S_DROP;
          end
        end else if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          if (misaligned) begin
            exc_next   = 1'b1;
            state_next = S_HALT;
          end else begin
            pc_next    = target;
            state_next = S_FETCH;
          end
        end else if (instr_ready) begin
          pc_next    = pc_plus4;
          state_next = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect_en && misaligned) begin
          exc_next   = 1'b1;
          state_next = imem_ack ? S_HALT : S_DRAIN;
        end else begin
          if (redirect_en) pend_next = target;
          if (imem_ack) begin
            pc_next    = redirect_en ? target : pend_pc;
            state_next = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (imem_ack) state_next = S_HALT;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// tb_instruction_fetch: directed scenarios plus randomized traffic against a protocol-level model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef MISALIGN_CHECK_EN
  logic        fetch_exc;
`endif

  instruction_fetch #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc)
`ifdef MISALIGN_CHECK_EN
    ,
    .fetch_exc   (fetch_exc)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected behaviour for the upcoming cycle, derived from handshake rules
  logic        exp_req;
  logic        exp_valid;
  logic [31:0] exp_addr;
  logic [31:0] exp_pc;
  logic        stale;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
  endfunction

  task automatic do_reset(input int n);
    reset       = 1'b1;
    imem_ack    = 1'b0;
    redirect_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("rst_req",   32'(imem_req),    32'd0);
      check_val("rst_valid", 32'(instr_valid), 32'd0);
      check_val("rst_instr", instr,            32'd0);
      check_val("rst_pc",    pc_out,           RESET_PC);
`ifdef MISALIGN_CHECK_EN
      check_val("rst_exc",   32'(fetch_exc),   32'd0);
`endif
      // a stray late ack while reset is high must be ignored
      imem_ack    = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom_range(0, 1));
      redirect_en = 1'($urandom_range(0, 1));
      redirect_pc = $urandom;
    end
    reset       = 1'b0;
    imem_ack    = 1'b0;
    redirect_en = 1'b0;
    exp_req     = 1'b1;
    exp_valid   = 1'b0;
    exp_addr    = RESET_PC;
    exp_pc      = RESET_PC;
    stale       = 1'b0;
    #1;
  endtask

  // Check this cycle's outputs, apply inputs, advance the model by one clock.
  task automatic cycle(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic [31:0] t;
    logic        delivered;
    check_val("imem_req",    32'(imem_req),    32'(exp_req));
    check_val("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_req) check_val("imem_addr", imem_addr, exp_addr);
    if (exp_valid) begin
      check_val("pc_out",   pc_out,   exp_pc);
      check_val("instr",    instr,    mem_word(exp_pc));
      check_val("pc_plus4", pc_plus4, exp_pc + 32'd4);
    end
`ifdef MISALIGN_CHECK_EN
    check_val("fetch_exc", 32'(fetch_exc), 32'd0);
`endif
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(imem_addr) : $urandom;
    instr_ready = rdy;
    redirect_en = redir;
    redirect_pc = tgt;
    t = tgt & 32'hFFFF_FFFC;
    if (exp_valid) begin
      if (redir) begin
        exp_pc = t; exp_valid = 1'b0; exp_req = 1'b1; exp_addr = t;
      end else if (rdy) begin
        exp_pc = exp_pc + 32'd4; exp_valid = 1'b0; exp_req = 1'b1; exp_addr = exp_pc;
      end
    end else if (exp_req) begin
      if (ack) begin
        delivered = !stale && !redir;
        if (redir) exp_pc = t;
        stale = 1'b0;
        if (delivered) begin
          exp_valid = 1'b1; exp_req = 1'b0;
        end else begin
          exp_addr = exp_pc;
        end
      end else if (redir) begin
        stale  = 1'b1;
        exp_pc = t;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // reset and first request
    do_reset(2);
    check_val("t1_addr", imem_addr, 32'h0040_0000);
    check_val("t1_req",  32'(imem_req), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check_val("t2_instr",    instr,    32'h0050_0093);
    check_val("t2_pc_plus4", pc_plus4, 32'h0040_0004);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check_val("t2_next_addr", imem_addr, 32'h0040_0004);
    check_val("t2_valid_off", 32'(instr_valid), 32'd0);

    // hold with ready low
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      check_val("t3_pc",  pc_out, 32'h0040_0004);
      check_val("t3_req", 32'(imem_req), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, '0);
    end

    // redirect wins over ready
    cycle(1'b0, 1'b1, 1'b1, 32'h0040_0020);
    check_val("t4_addr", imem_addr, 32'h0040_0020);

    // redirect while fetch outstanding, ack two cycles late
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0040_0040);
    for (int i = 0; i < 2; i++) begin
      check_val("t5_hold_addr", imem_addr, 32'h0040_0024);
      check_val("t5_no_valid",  32'(instr_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, '0);
    end
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_val("t5_new_addr", imem_addr, 32'h0040_0040);
    check_val("t5_no_valid2", 32'(instr_valid), 32'd0);

    // misaligned redirect target
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0040_0022);
`ifdef MISALIGN_CHECK_EN
    redirect_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("t6_exc",   32'(fetch_exc),   32'd1);
      check_val("t6_req",   32'(imem_req),    32'd0);
      check_val("t6_valid", 32'(instr_valid), 32'd0);
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    do_reset(2);
`else
    check_val("t6_addr", imem_addr, 32'h0040_0020);
`endif

    // randomized traffic, one mid-run reset
    for (int k = 0; k < 3000; k++) begin
      logic        ack;
      logic        rdy;
      logic        rd;
      logic [31:0] tg;
      if (k == 1500) do_reset(2 + $urandom_range(0, 2));
      ack = exp_req && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) == 0)
        tg = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      else
        tg = RESET_PC + (32'($urandom_range(0, 255)) << 2);
`ifdef MISALIGN_CHECK_EN
      tg = tg & 32'hFFFF_FFFC;
`else
      tg = tg | 32'($urandom_range(0, 3));
`endif
      cycle(ack, rdy, rd, tg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
